// File: rtl/sdram_arbiter_if.sv
// Client request bus plus sdram_controller command port for sdram_arbiter.
// master = client/controller side, slave = the arbiter itself.
interface sdram_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS-1:0]            we;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_PORTS-1:0]            ack;
  logic [DATA_WIDTH-1:0]           rdata;
  logic                            err;
  logic [1:0]                      sd_command;
  logic [ADDR_WIDTH-1:0]           sd_address;
  logic [DATA_WIDTH-1:0]           sd_write;
  logic [DATA_WIDTH-1:0]           sd_read;
  logic                            sd_read_valid;
  logic                            sd_write_done;

  modport slave (
    input  req, we, addr, wdata, sd_read, sd_read_valid, sd_write_done,
    output ack, rdata, err, sd_command, sd_address, sd_write
  );

  modport master (
    output req, we, addr, wdata, sd_read, sd_read_valid, sd_write_done,
    input  ack, rdata, err, sd_command, sd_address, sd_write
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares one sdram_controller command port between NUM_PORTS single-word requesters.
// Define SDRAM_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module sdram_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RESET_HOLDOFF  = 16
) (
  input logic           clk,
  input logic           rst_n,
  sdram_arbiter_if.slave bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = (RESET_HOLDOFF > 1) ? $clog2(RESET_HOLDOFF) : 1;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

  typedef enum logic [1:0] {HOLDOFF, IDLE, ISSUE, RESPOND} state_t;

  state_t                 state;
  logic [HW-1:0]          holdoff_cnt;
  logic [TW-1:0]          timeout_cnt;
  logic [PW-1:0]          grant;
  logic                   issued_write;
  logic [NUM_PORTS-1:0]   ack_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   err_q;
  logic [1:0]             command_q;
  logic [ADDR_WIDTH-1:0]  address_q;
  logic [DATA_WIDTH-1:0]  write_q;

  logic [PW-1:0]          winner;
  logic                   winner_we;
  logic                   any_req;
  logic                   done_ok;

  assign any_req = |bus.req;

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
  // Scan downwards so the lowest-index requester is the last to overwrite.
  always_comb begin
    winner = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((bus.req & (ONE << i)) != '0)
        winner = PW'(i);
    end
  end
`else
  logic [PW-1:0] last_grant;

  // Distance 1 from last_grant is highest priority, so scan from farthest to nearest.
  always_comb begin
    winner = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if ((bus.req & (ONE << ((int'(last_grant) + k) % NUM_PORTS))) != '0)
        winner = PW'((int'(last_grant) + k) % NUM_PORTS);
    end
  end
`endif

  assign winner_we = |(bus.we & (ONE << winner));

  // Only a completion pulse matching the issued direction finishes the transaction.
  assign done_ok = issued_write ? bus.sd_write_done : bus.sd_read_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HOLDOFF;
      holdoff_cnt  <= HW'(RESET_HOLDOFF - 1);
      timeout_cnt  <= '0;
      grant        <= '0;
      issued_write <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      command_q    <= CMD_IDLE;
      address_q    <= '0;
      write_q      <= '0;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
      last_grant   <= PW'(NUM_PORTS - 1);
`endif
    end else begin
      case (state)
        HOLDOFF: begin
          if (holdoff_cnt == '0)
            state <= IDLE;
          else
            holdoff_cnt <= holdoff_cnt - HW'(1);
        end

        IDLE: begin
          if (any_req) begin
            grant        <= winner;
            issued_write <= winner_we;
            command_q    <= winner_we ? CMD_WRITE : CMD_READ;
            address_q    <= ADDR_WIDTH'(bus.addr >> (int'(winner) * ADDR_WIDTH));
            write_q      <= DATA_WIDTH'(bus.wdata >> (int'(winner) * DATA_WIDTH));
            timeout_cnt  <= TW'(TIMEOUT_CYCLES);
            state        <= ISSUE;
          end
        end

        // Command stays on the bus until completion or timeout, then drops with ack.
        ISSUE: begin
          if (timeout_cnt != '0)
            timeout_cnt <= timeout_cnt - TW'(1);
          if (done_ok) begin
            if (!issued_write)
              rdata_q <= bus.sd_read;
            command_q <= CMD_IDLE;
            ack_q     <= ONE << grant;
            state     <= RESPOND;
          end else if (timeout_cnt <= TW'(1)) begin
            command_q <= CMD_IDLE;
            err_q     <= 1'b1;
            ack_q     <= ONE << grant;
            state     <= RESPOND;
          end
        end

        RESPOND: begin
          ack_q <= '0;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
          last_grant <= grant;
`endif
          state <= IDLE;
        end

        default: state <= HOLDOFF;
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;
  assign bus.sd_command = command_q;
  assign bus.sd_address = address_q;
  assign bus.sd_write   = write_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; the controller side is driven by hand.
// Honours SDRAM_ARB_FIXED_PRIORITY_EN for the expected contention grant order.
module tb_sdram_arbiter;
  localparam int NP = 2;
  localparam int AW = 24;
  localparam int DW = 16;

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  sdram_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(64), .RESET_HOLDOFF(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic write,
                               input logic [AW-1:0] address, input logic [DW-1:0] data);
    bus.req[port] = 1'b1;
    bus.we[port]  = write;
    bus.addr[port*AW +: AW]  = address;
    bus.wdata[port*DW +: DW] = data;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    int waited;
    int exp_port;
    logic [AW-1:0] exp_addr;

    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    bus.sd_read = '0; bus.sd_read_valid = 1'b0; bus.sd_write_done = 1'b0;
    applyStimulus(0, 1'b0, 24'h000456, 16'h0000);
    bus.addr[1*AW +: AW] = 24'h000789;

    #2;
    checkOutput("reset_cmd",   32'(bus.sd_command), 32'd0);
    checkOutput("reset_addr",  32'(bus.sd_address), 32'd0);
    checkOutput("reset_write", 32'(bus.sd_write),   32'd0);
    checkOutput("reset_ack",   32'(bus.ack),        32'd0);
    checkOutput("reset_rdata", 32'(bus.rdata),      32'd0);
    checkOutput("reset_err",   32'(bus.err),        32'd0);

    #10 rst_n = 1'b1;

    // Hold-off: req[0] held from release, no command for 16 cycles.
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (bus.sd_command !== 2'd0) bad++;
    end
    checkOutput("holdoff_quiet", 32'(bad), 32'd0);
    step(1);
    checkOutput("holdoff_first_cmd",  32'(bus.sd_command), 32'd2);
    checkOutput("holdoff_first_addr", 32'(bus.sd_address), 32'h000456);

    // Wrong-direction pulse must be ignored for a read.
    bus.sd_write_done = 1'b1;
    step(1);
    bus.sd_write_done = 1'b0;
    checkOutput("read_ignore_done_cmd", 32'(bus.sd_command), 32'd2);
    checkOutput("read_ignore_done_ack", 32'(bus.ack), 32'd0);

    bus.sd_read = 16'h1234; bus.sd_read_valid = 1'b1;
    step(1);
    bus.sd_read_valid = 1'b0; bus.req = '0;
    checkOutput("read_ack",   32'(bus.ack),        32'b01);
    checkOutput("read_rdata", 32'(bus.rdata),      32'h1234);
    checkOutput("read_cmd0",  32'(bus.sd_command), 32'd0);
    step(1);
    checkOutput("read_ack_drop", 32'(bus.ack), 32'd0);

    // Single write from port 1.
    applyStimulus(1, 1'b1, 24'h000123, 16'hBEEF);
    step(1);
    checkOutput("write_cmd",  32'(bus.sd_command), 32'd1);
    checkOutput("write_addr", 32'(bus.sd_address), 32'h000123);
    checkOutput("write_data", 32'(bus.sd_write),   32'hBEEF);
    step(3);
    checkOutput("write_hold_cmd",  32'(bus.sd_command), 32'd1);
    checkOutput("write_hold_data", 32'(bus.sd_write),   32'hBEEF);
    checkOutput("write_hold_ack",  32'(bus.ack),        32'd0);
    bus.sd_write_done = 1'b1;
    step(1);
    bus.sd_write_done = 1'b0; bus.req = '0;
    checkOutput("write_ack",  32'(bus.ack),        32'b10);
    checkOutput("write_cmd0", 32'(bus.sd_command), 32'd0);
    step(1);
    checkOutput("write_ack_drop", 32'(bus.ack), 32'd0);

    // Contention: both ports keep requesting reads.
    applyStimulus(0, 1'b0, 24'h000456, 16'h0000);
    applyStimulus(1, 1'b0, 24'h000789, 16'h0000);
    for (int t = 0; t < 4; t++) begin
      exp_port = FIXED ? 0 : (t % 2);
      exp_addr = (exp_port == 0) ? 24'h000456 : 24'h000789;
      step(1);
      checkOutput($sformatf("cont%0d_cmd", t),  32'(bus.sd_command), 32'd2);
      checkOutput($sformatf("cont%0d_addr", t), 32'(bus.sd_address), 32'(exp_addr));
      bus.sd_read = 16'h1000 + 16'(t); bus.sd_read_valid = 1'b1;
      step(1);
      bus.sd_read_valid = 1'b0;
      checkOutput($sformatf("cont%0d_ack", t),   32'(bus.ack),   32'(1 << exp_port));
      checkOutput($sformatf("cont%0d_rdata", t), 32'(bus.rdata), 32'h1000 + 32'(t));
      step(1);
    end
    bus.req = '0;

    // Timeout: write never completes; stray read_valid must not finish it.
    applyStimulus(0, 1'b1, 24'h000AAA, 16'h5555);
    step(1);
    checkOutput("to_cmd", 32'(bus.sd_command), 32'd1);
    checkOutput("to_err_before", 32'(bus.err), 32'd0);
    bus.sd_read_valid = 1'b1;
    waited = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      waited++;
      if (bus.ack !== '0) break;
    end
    bus.sd_read_valid = 1'b0; bus.req = '0;
    checkOutput("to_cycles", 32'(waited),        32'd64);
    checkOutput("to_ack",    32'(bus.ack),        32'b01);
    checkOutput("to_err",    32'(bus.err),        32'd1);
    checkOutput("to_cmd0",   32'(bus.sd_command), 32'd0);
    step(1);

    applyStimulus(1, 1'b0, 24'h000789, 16'h0000);
    step(1);
    checkOutput("after_to_cmd",  32'(bus.sd_command), 32'd2);
    checkOutput("after_to_addr", 32'(bus.sd_address), 32'h000789);
    bus.sd_read = 16'hCAFE; bus.sd_read_valid = 1'b1;
    step(1);
    bus.sd_read_valid = 1'b0; bus.req = '0;
    checkOutput("after_to_ack",   32'(bus.ack),   32'b10);
    checkOutput("after_to_rdata", 32'(bus.rdata), 32'hCAFE);
    checkOutput("err_sticky",     32'(bus.err),   32'd1);
    step(1);

    // Mid-transaction reset, then stray valid pulses during hold-off.
    applyStimulus(0, 1'b0, 24'h000456, 16'h0000);
    step(1);
    checkOutput("mid_cmd", 32'(bus.sd_command), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_cmd",  32'(bus.sd_command), 32'd0);
    checkOutput("mid_rst_ack",  32'(bus.ack),        32'd0);
    checkOutput("mid_rst_err",  32'(bus.err),        32'd0);
    checkOutput("mid_rst_addr", 32'(bus.sd_address), 32'd0);
    bus.req = '0;
    #3 rst_n = 1'b1;
    bus.sd_read_valid = 1'b1; bus.sd_read = 16'hDEAD;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus.ack !== '0 || bus.sd_command !== 2'd0) bad++;
    end
    bus.sd_read_valid = 1'b0;
    checkOutput("holdoff_stray_valid", 32'(bad), 32'd0);
    checkOutput("holdoff_rdata", 32'(bus.rdata), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
